stump_mem_responder: RTL and testbench

//  Memory-side responder for the Stump CPU bus: answers the CPU's address/mem_ren/mem_wen/data_out

---
 rtl/stump_mem_responder.sv | 123 ++++++++++++
 tb/tb_stump_mem_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stump_mem_responder.sv
// Stump CPU memory responder: RAM, console TX FIFO and I/O page with zero-wait-state reads.
// Optional cycle timer at I/O offset 0x02 is built when STUMP_MEM_TIMER_EN is defined.
module stump_mem_responder #(
  parameter int          ADDR_W     = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] IO_BASE    = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address,
  input  logic [15:0] cpu_wdata,
  input  logic        mem_wen,
  input  logic        mem_ren,
  output logic [15:0] cpu_rdata,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [15:0]      r_ram [2**ADDR_W];
  logic [15:0]      r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  logic             w_io_sel;
  logic [7:0]       w_off;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_push_ok;
  logic             w_ovf_set;
  logic             w_stat_rd;
  logic [3:0]       w_cnt4;
  logic [15:0]      w_status;
  logic [15:0]      w_timer_rd;

  assign w_io_sel  = (address[15:8] == IO_BASE[15:8]);
  assign w_off     = address[7:0];
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push    = mem_wen && w_io_sel && (w_off == 8'h00);
  assign w_pop     = !w_empty && tx_ready;
  // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;
  assign w_stat_rd = mem_ren && w_io_sel && (w_off == 8'h01);
  assign w_cnt4    = 4'(r_count);
  assign w_status  = {8'h00, w_cnt4, 1'b0, r_ovf, w_empty, w_full};

  assign tx_valid  = !w_empty;
  assign tx_data   = r_fifo[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (mem_wen && !w_io_sel) begin
      r_ram[address[ADDR_W-1:0]] <= cpu_wdata;
    end
    if (w_push_ok) begin
      r_fifo[r_wr_ptr] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_stat_rd) begin
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef STUMP_MEM_TIMER_EN
  logic [15:0] r_timer;
  logic        w_timer_wr;

  assign w_timer_wr = mem_wen && w_io_sel && (w_off == 8'h02);
  assign w_timer_rd = r_timer;

  always_ff @(posedge clk) begin
    if (rst || w_timer_wr) begin
      r_timer <= 16'h0000;
    end else begin
      r_timer <= r_timer + 16'h0001;
    end
  end
`else
  assign w_timer_rd = 16'h0000;
`endif

  always_comb begin
    cpu_rdata = 16'h0000;
    if (mem_ren) begin
      if (w_io_sel) begin
        case (w_off)
          8'h01:   cpu_rdata = w_status;
          8'h02:   cpu_rdata = w_timer_rd;
          default: cpu_rdata = 16'h0000;
        endcase
      end else begin
        cpu_rdata = r_ram[address[ADDR_W-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_stump_mem_responder.sv
// Bench for stump_mem_responder: queue/array reference model checked every cycle,
// plus directed literal checks on the memory, FIFO, STATUS and timer behaviour.
module tb_stump_mem_responder;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [15:0] address;
  logic [15:0] cpu_wdata;
  logic        mem_wen;
  logic        mem_ren;
  logic [15:0] cpu_rdata;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks = 0;
  int errors = 0;

  stump_mem_responder #(.ADDR_W(8), .FIFO_DEPTH(DEPTH), .IO_BASE(16'hFF00)) dut (
    .clk(clk), .rst(rst), .address(address), .cpu_wdata(cpu_wdata),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .cpu_rdata(cpu_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] m_ram [256];
  bit          m_written [256];
  logic [15:0] m_q [$];
  bit          m_ovf;
  int unsigned m_timer;
  bit          m_ok = 1'b0;

  function automatic bit is_io(input logic [15:0] a);
    return a[15:8] == 8'hFF;
  endfunction

  function automatic logic [15:0] m_status();
    int n;
    n = m_q.size();
    return {8'h00, 4'(n), 1'b0, m_ovf, (n == 0), (n == DEPTH)};
  endfunction

  function automatic logic [15:0] m_rdata();
    if (!mem_ren) return 16'h0000;
    if (is_io(address)) begin
      if (address[7:0] == 8'h01) return m_status();
`ifdef STUMP_MEM_TIMER_EN
      if (address[7:0] == 8'h02) return 16'(m_timer);
`endif
      return 16'h0000;
    end
    return m_ram[address[7:0]];
  endfunction

  always @(posedge clk) begin
    bit pop, push, stat, tclr;
    pop  = (m_q.size() != 0) && tx_ready;
    push = mem_wen && is_io(address) && (address[7:0] == 8'h00);
    stat = mem_ren && is_io(address) && (address[7:0] == 8'h01);
    tclr = mem_wen && is_io(address) && (address[7:0] == 8'h02);
    if (mem_wen && !is_io(address)) begin
      m_ram[address[7:0]]     = cpu_wdata;
      m_written[address[7:0]] = 1'b1;
    end
    if (rst) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_timer = 0;
      m_ok    = 1'b1;
    end else if (m_ok) begin
      if (pop) void'(m_q.pop_front());
      if (stat) m_ovf = 1'b0;
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(cpu_wdata);
        else m_ovf = 1'b1;
      end
      m_timer = tclr ? 0 : ((m_timer + 1) & 32'hFFFF);
    end
  end

  // Continuous comparison against the model
  always @(negedge clk) begin
    if (m_ok) begin
      checks++;
      if (tx_valid !== (m_q.size() != 0)) begin
        errors++;
        $display("FAIL model_tx_valid t=%0t got=%0b exp=%0b", $time, tx_valid, m_q.size() != 0);
      end
      if (m_q.size() != 0) begin
        checks++;
        if (tx_data !== m_q[0]) begin
          errors++;
          $display("FAIL model_tx_data t=%0t got=%h exp=%h", $time, tx_data, m_q[0]);
        end
      end
      if (!(mem_ren && !is_io(address) && !m_written[address[7:0]])) begin
        checks++;
        if (cpu_rdata !== m_rdata()) begin
          errors++;
          $display("FAIL model_cpu_rdata t=%0t addr=%h got=%h exp=%h", $time, address, cpu_rdata, m_rdata());
        end
      end
    end
  end

  task automatic lit(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [15:0] a, input logic [15:0] d);
    mem_wen = w; mem_ren = r; address = a; cpu_wdata = d;
  endtask

  initial begin
    rst = 1'b1; tx_ready = 1'b0;
    drive(0, 0, 16'h0000, 16'h0000);
    tick(); tick();
    rst = 1'b0;

    // Reset state
    drive(0, 1, 16'hFF01, 16'h0000);
    @(negedge clk);
    lit("reset_status", cpu_rdata, 16'h0002);
    lit("reset_tx_valid", {15'd0, tx_valid}, 16'h0000);
    tick();

    // RAM write/read, alias, read-disable
    drive(1, 0, 16'h0010, 16'hBEEF); tick();
    drive(0, 1, 16'h0010, 16'h0000);
    @(negedge clk); lit("ram_read", cpu_rdata, 16'hBEEF); tick();
    drive(0, 1, 16'h0110, 16'h0000);
    @(negedge clk); lit("ram_alias", cpu_rdata, 16'hBEEF); tick();
    drive(0, 0, 16'h0010, 16'h0000);
    @(negedge clk); lit("ren_low", cpu_rdata, 16'h0000); tick();

    // Simultaneous write+read shows pre-write data
    drive(1, 0, 16'h0020, 16'h1234); tick();
    drive(1, 1, 16'h0020, 16'h5678);
    @(negedge clk); lit("rw_prewrite", cpu_rdata, 16'h1234); tick();
    drive(0, 1, 16'h0020, 16'h0000);
    @(negedge clk); lit("rw_postwrite", cpu_rdata, 16'h5678); tick();

    // Fill FIFO, then overflow
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 16'hFF00, 16'h0041 + 16'(i)); tick();
    end
    drive(0, 1, 16'hFF01, 16'h0000);
    @(negedge clk); lit("status_full", cpu_rdata, 16'h0041); tick();
    drive(1, 0, 16'hFF00, 16'h0045); tick();
    drive(0, 1, 16'hFF01, 16'h0000);
    @(negedge clk); lit("status_ovf", cpu_rdata, 16'h0045); tick();
    @(negedge clk); lit("status_ovf_cleared", cpu_rdata, 16'h0041); tick();

    // Drain
    drive(0, 0, 16'h0000, 16'h0000);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); lit("drain_data", tx_data, 16'h0041 + 16'(i)); tick();
    end
    drive(0, 1, 16'hFF01, 16'h0000);
    @(negedge clk);
    lit("drain_valid", {15'd0, tx_valid}, 16'h0000);
    lit("drain_status", cpu_rdata, 16'h0002);
    tick();

    // Push+pop while empty: push lands, no bypass
    drive(1, 0, 16'hFF00, 16'h0055); tick();
    tx_ready = 1'b0;
    drive(0, 1, 16'hFF01, 16'h0000);
    @(negedge clk);
    lit("empty_pushpop_data", tx_data, 16'h0055);
    lit("empty_pushpop_status", cpu_rdata, 16'h0010);
    tick();
    tx_ready = 1'b1; drive(0, 0, 16'h0000, 16'h0000); tick();
    tx_ready = 1'b0;

    // Full FIFO with push+pop on the same edge
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 16'hFF00, 16'h0091 + 16'(i)); tick();
    end
    tx_ready = 1'b1;
    drive(1, 0, 16'hFF00, 16'h0099); tick();
    drive(0, 1, 16'hFF01, 16'h0000);
    @(negedge clk);
    lit("full_pushpop_status", cpu_rdata, 16'h0041);
    lit("full_pushpop_head", tx_data, 16'h0092);
    tick();
    drive(0, 0, 16'h0000, 16'h0000);
    @(negedge clk); lit("full_pushpop_d3", tx_data, 16'h0093); tick();
    @(negedge clk); lit("full_pushpop_d4", tx_data, 16'h0094); tick();
    @(negedge clk); lit("full_pushpop_last", tx_data, 16'h0099); tick();
    @(negedge clk); lit("full_pushpop_empty", {15'd0, tx_valid}, 16'h0000);
    tx_ready = 1'b0;

    // Timer
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    drive(0, 1, 16'hFF02, 16'h0000);
`ifdef STUMP_MEM_TIMER_EN
    @(negedge clk); lit("timer_10", cpu_rdata, 16'h000A); tick();
    drive(1, 0, 16'hFF02, 16'hABCD); tick();
    drive(0, 1, 16'hFF02, 16'h0000);
    @(negedge clk); lit("timer_clear", cpu_rdata, 16'h0000);
    for (int i = 0; i < 65536; i++) tick();
    @(negedge clk); lit("timer_wrap", cpu_rdata, 16'h0000); tick();
`else
    @(negedge clk); lit("timer_absent", cpu_rdata, 16'h0000); tick();
`endif

    // Reset mid-drain
    drive(0, 0, 16'h0000, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 16'hFF00, 16'h00A1 + 16'(i)); tick();
    end
    drive(0, 0, 16'h0000, 16'h0000);
    tx_ready = 1'b1; tick();
    drive(0, 1, 16'hFF01, 16'h0000);
    @(negedge clk); lit("middrain_count3", cpu_rdata, 16'h0030);
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    lit("rst_tx_valid", {15'd0, tx_valid}, 16'h0000);
    lit("rst_status", cpu_rdata, 16'h0002);
    tick();
    drive(0, 1, 16'h0010, 16'h0000);
    @(negedge clk); lit("ram_survives_rst", cpu_rdata, 16'hBEEF); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
